pulse_train_gen: RTL and testbench

Parametrised periodic pulse generator: after a `go` strobe it emits a pulse of programmable width every programmable number of enabled clock cycles. It runs either continuously or for a programmed burst of N pulses, then signals `done`. It is the generalised successor of the team's fixed every-10-cycles pulser and sits between control logic and any block needing a periodic strobe or gate (sampling ticks, LED/PWM-style gating, test stimulus). Clock-enable-style pausing via `en` is retained.

---
 rtl/pulse_train_gen.sv | 169 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Purpose: programmable periodic pulse generator (continuous or N-pulse burst) with en pausing.
// Latency: first pulse registered after edge P_l following an accepted go; done one cycle after drain.
// Backpressure: none; en low freezes all counters and forces pulse low until en returns.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   go, stop            start request (IDLE only), synchronous abort (wins over go)
//   en                  count enable
//   mode                0 = continuous, 1 = burst (latched on go)
//   period, width       P and W in cycles (latched and clamped on go)
//   burst_n             pulses per burst (latched and clamped on go)
//   pulse, busy, done   registered pulse, not-IDLE flag, one-cycle completion strobe
//   pulse_cnt           pulses emitted since the last accepted go (wraps)
module pulse_train_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               stop,
    input  logic               en,
    input  logic               mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   width,
    input  logic [BURST_W-1:0] burst_n,
    output logic               pulse,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0]   wrem, wrem_nx;
    logic [BURST_W-1:0] pcnt_nx;
    logic               pulse_nx, done_nx;
    logic               latch;

    // Latched, clamped configuration
    logic [CNT_W-1:0]   p_l, w_l;
    logic [BURST_W-1:0] n_l;
    logic               mode_l;

    // Clamped view of the live config inputs, captured only on an accepted go
    logic [CNT_W-1:0]   p_clamp, w_clamp;
    logic [BURST_W-1:0] n_clamp;

    always_comb begin
        p_clamp = (period == '0) ? CNT_W'(1) : period;
        if (width == '0)
            w_clamp = CNT_W'(1);
        else if (width > p_clamp)
            w_clamp = p_clamp;
        else
            w_clamp = width;
        n_clamp = (burst_n == '0) ? BURST_W'(1) : burst_n;
    end

    logic terminal;
    logic last_pulse;

    // Clamping keeps cnt in 0..p_l-1, so equality with p_l-1 is the wrap point
    assign terminal   = (state == RUN) && en && (cnt == p_l - CNT_W'(1));
    assign last_pulse = mode_l && (pulse_cnt == n_l - BURST_W'(1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wrem_nx  = wrem;
        pcnt_nx  = pulse_cnt;
        pulse_nx = 1'b0;
        done_nx  = 1'b0;
        latch    = 1'b0;

        if (stop) begin
            state_nx = IDLE;
            wrem_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        latch    = 1'b1;
                        state_nx = RUN;
                        cnt_nx   = '0;
                        wrem_nx  = '0;
                        pcnt_nx  = '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (terminal) begin
                            cnt_nx   = '0;
                            pulse_nx = 1'b1;
                            // Start cycle is this one; wrem counts the cycles still owed
                            wrem_nx  = w_l - CNT_W'(1);
                            pcnt_nx  = pulse_cnt + BURST_W'(1);
                            if (last_pulse)
                                state_nx = DRAIN;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                            if (wrem != '0) begin
                                wrem_nx  = wrem - CNT_W'(1);
                                pulse_nx = 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (en) begin
                        if (wrem != '0) begin
                            wrem_nx  = wrem - CNT_W'(1);
                            pulse_nx = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            wrem      <= '0;
            pulse_cnt <= '0;
            pulse     <= 1'b0;
            done      <= 1'b0;
            p_l       <= '0;
            w_l       <= '0;
            n_l       <= '0;
            mode_l    <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            wrem      <= wrem_nx;
            pulse_cnt <= pcnt_nx;
            pulse     <= pulse_nx;
            done      <= done_nx;
            if (latch) begin
                p_l    <= p_clamp;
                w_l    <= w_clamp;
                n_l    <= n_clamp;
                mode_l <= mode;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed scenarios followed by randomized runs.
// Expected outputs per clock edge come from an enabled-cycle-count model and are queued;
// a negedge monitor pops and compares against the DUT outputs.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] period = '0;
    logic [7:0] width = '0;
    logic [7:0] burst_n = '0;
    logic       pulse, busy, done;
    logic [7:0] pulse_cnt;

    pulse_train_gen #(.CNT_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .stop      (stop),
        .en        (en),
        .mode      (mode),
        .period    (period),
        .width     (width),
        .burst_n   (burst_n),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       pulse;
        bit       busy;
        bit       done;
        bit [7:0] pcnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a run is described by k, the number of enabled cycles since go.
    // Pulses start at k = j*P and last W enabled cycles; a burst ends at k = N*P + W.
    initial begin
        bit run = 0;
        bit m_mode = 0;
        int k = 0, pl = 1, wl = 1, nl = 1, pcnt = 0;
        bit ep = 0, ed = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                run = 0; k = 0; pcnt = 0; ep = 0; ed = 0;
                q.delete();
            end else begin
                ed = 0;
                if (stop) begin
                    run = 0; ep = 0;
                end else if (!run) begin
                    ep = 0;
                    if (go) begin
                        m_mode = mode;
                        pl = (period == 0) ? 1 : int'(period);
                        wl = (width == 0) ? 1 : ((int'(width) > pl) ? pl : int'(width));
                        nl = (burst_n == 0) ? 1 : int'(burst_n);
                        run = 1; k = 0; pcnt = 0;
                    end
                end else if (!en) begin
                    ep = 0;
                end else begin
                    k++;
                    if (m_mode && k == nl * pl + wl) begin
                        run = 0; ep = 0; ed = 1;
                    end else begin
                        ep = (k >= pl) && ((k % pl) < wl);
                        pcnt = k / pl;
                        if (m_mode && pcnt > nl) pcnt = nl;
                    end
                end
                q.push_back('{pulse: ep, busy: run, done: ed, pcnt: 8'(pcnt)});
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_pulse", int'(pulse), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_pulse_cnt", int'(pulse_cnt), 0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check("pulse", int'(pulse), int'(e.pulse));
                check("busy", int'(busy), int'(e.busy));
                check("done", int'(done), int'(e.done));
                check("pulse_cnt", int'(pulse_cnt), int'(e.pcnt));
            end
        end
    end

    // One clock: inputs change 2 time units after the rising edge
    task automatic step(input bit g, input bit s, input bit e);
        go = g; stop = s; en = e;
        @(posedge clk);
        #2;
    endtask

    task automatic start(input bit m, input int p, input int w, input int n);
        mode = m; period = 8'(p); width = 8'(w); burst_n = 8'(n);
        step(1, 0, 1);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    initial begin
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_en(3);

        // Continuous P=10 W=1
        start(0, 10, 1, 0);
        run_en(35);
        step(0, 1, 1);
        run_en(2);

        // Burst P=5 W=3 N=3
        start(1, 5, 3, 3);
        run_en(25);

        // Pause splitting a pulse
        start(0, 10, 4, 0);
        run_en(11);
        step(0, 0, 0);
        step(0, 0, 0);
        run_en(15);
        step(0, 1, 1);

        // Clamps
        start(0, 0, 0, 0);
        run_en(10);
        step(0, 1, 1);
        start(0, 4, 9, 0);
        run_en(15);
        step(0, 1, 1);

        // Stop during second pulse of an N=5 burst
        start(1, 5, 3, 5);
        run_en(10);
        step(0, 1, 1);
        run_en(3);

        // go together with stop in IDLE
        mode = 1; period = 8'd3; width = 8'd1; burst_n = 8'd2;
        step(1, 1, 1);
        run_en(4);

        // W==P burst and P=1 burst
        start(1, 3, 3, 2);
        run_en(10);
        start(1, 1, 1, 4);
        run_en(8);

        // Asynchronous reset mid-burst, then clean restart
        start(1, 5, 3, 4);
        run_en(7);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_pulse", int'(pulse), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_cnt", int'(pulse_cnt), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_en(3);
        start(1, 6, 2, 2);
        run_en(18);

        // Randomized runs; config inputs churn every cycle to show they are ignored
        for (int r = 0; r < 40; r++) begin
            start(1'($urandom_range(0, 1)), $urandom_range(0, 12),
                  $urandom_range(0, 14), $urandom_range(0, 5));
            for (int c = 0, n = $urandom_range(20, 120); c < n; c++) begin
                mode    = 1'($urandom_range(0, 1));
                period  = 8'($urandom_range(0, 12));
                width   = 8'($urandom_range(0, 14));
                burst_n = 8'($urandom_range(0, 5));
                step(($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 9) != 0));
            end
            step(0, 1, 1);
        end

        run_en(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
